// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch byte queue between the ICache and the decoder.
// Requests 64-byte lines in order, keeps two of them in a 128-byte circular
// buffer and presents a 15-byte window at decode_rip to the decoder.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no request outstanding; launch one when a full line fits
//   REQ   | request outstanding; line is written on icache_done
//   FLUSH | request outstanding across a redirect; its data is dropped
module fetch_queue #(
    parameter int LINE_BYTES   = 64,
    parameter int BUF_BYTES    = 128,
    parameter int WINDOW_BYTES = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        set_rip,
    input  logic [63:0]                 new_rip,
    output logic                        icache_enable,
    output logic [63:0]                 icache_addr,
    input  logic [LINE_BYTES*8-1:0]     icache_rdata,
    input  logic                        icache_done,
    output logic [0:WINDOW_BYTES*8-1]   decode_bytes,
    output logic [63:0]                 decode_rip,
    input  logic [7:0]                  bytes_decoded,
    output logic                        if_dc,
    input  logic                        dc_if
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(BUF_BYTES);
    localparam logic signed [63:0] LINE_S = 64'(LINE_BYTES);
    localparam logic signed [63:0] WIN_S  = 64'(WINDOW_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_fill_addr;
    logic [63:0] r_decode_rip;
    logic [63:0] r_icache_addr;
    logic        r_armed;
    logic [7:0]  r_buf [BUF_BYTES];

    logic [63:0]      w_avail;
    logic             w_room;
    logic             w_if_dc;
    logic             w_consume;
    logic             w_fill;
    logic             w_launch;
    logic [IDX_W-1:0] w_slot_base;

    // Occupancy is signed: right after a redirect to an unaligned target the
    // bytes below new_rip in the first line count as negative space.
    assign w_avail     = r_fill_addr - r_decode_rip;
    assign w_room      = $signed(w_avail) <= LINE_S;
    assign w_if_dc     = (r_state != S_FLUSH) && ($signed(w_avail) >= WIN_S);
    assign w_consume   = w_if_dc && dc_if && (bytes_decoded != 8'd0)
                         && (bytes_decoded <= 8'(WINDOW_BYTES));
    assign w_fill      = (r_state == S_REQ) && icache_done && !set_rip;
    assign w_slot_base = r_fill_addr[IDX_W-1:0];

    assign if_dc         = w_if_dc;
    assign decode_rip    = r_decode_rip;
    assign icache_enable = (r_state != S_IDLE);
    assign icache_addr   = r_icache_addr;

    // Next-state logic; a response that coincides with a redirect still
    // retires the request so FLUSH never waits for a strobe that won't come.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!set_rip && r_armed && w_room) begin
                    w_state_nxt = S_REQ;
                    w_launch    = 1'b1;
                end
            end
            S_REQ: begin
                if (set_rip) begin
                    w_state_nxt = icache_done ? S_IDLE : S_FLUSH;
                end else if (icache_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (icache_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, pointers and request address; redirect overrides fill and consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_fill_addr   <= 64'd0;
            r_decode_rip  <= 64'd0;
            r_icache_addr <= 64'd0;
            r_armed       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_icache_addr <= r_fill_addr;
            end
            if (set_rip) begin
                r_decode_rip <= new_rip;
                r_fill_addr  <= {new_rip[63:OFF_W], {OFF_W{1'b0}}};
                r_armed      <= 1'b1;
            end else begin
                if (w_fill) begin
                    r_fill_addr <= r_fill_addr + 64'(LINE_BYTES);
                end
                if (w_consume) begin
                    r_decode_rip <= r_decode_rip + 64'(bytes_decoded);
                end
            end
        end
    end

    // Line storage; the slot is selected by the line bit of fill_addr.
    always_ff @(posedge clk) begin
        if (!reset && w_fill) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                r_buf[w_slot_base + IDX_W'(k)] <= icache_rdata[8*k +: 8];
            end
        end
    end

    // Decoder window, wrapping modulo the buffer size.
    always_comb begin
        decode_bytes = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            decode_bytes[8*i +: 8] = r_buf[r_decode_rip[IDX_W-1:0] + IDX_W'(i)];
        end
    end

endmodule
